// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle datapath.
// Works on operand magnitudes (shift-add multiply, restoring divide) and
// applies the signs in a final FIX cycle before writing Hi/Lo.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,        // synchronous, active-low
  input  logic             MultControl,
  input  logic             DivControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mag_a;     // |A|: multiplicand
  logic [WIDTH-1:0] r_mag_b;     // |B|: divisor
  logic [WIDTH-1:0] r_acc_hi;    // mult: running high half; div: partial remainder
  logic [WIDTH-1:0] r_acc_lo;    // mult: multiplier/low half; div: dividend -> quotient
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_is_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_divzero;

  // Multiply wins when both requests arrive together.
  logic w_start_mult;
  logic w_start_div;
  logic w_b_zero;
  logic w_last;

  assign w_start_mult = MultControl;
  assign w_start_div  = DivControl && !MultControl;
  assign w_b_zero     = (B == '0);
  assign w_last       = (r_count == CW'(WIDTH - 1));

  // Magnitudes fit WIDTH unsigned bits, so the most negative value is exact.
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_abs_a = A[WIDTH-1] ? ('0 - A) : A;
  assign w_abs_b = B[WIDTH-1] ? ('0 - B) : B;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the {carry, hi, lo} triple right by one.
  logic [WIDTH:0] w_madd;

  assign w_madd = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_a} : '0);

  // Restoring-divide step: shift next dividend bit into the remainder and
  // subtract the divisor; a borrow means the quotient bit is 0.
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH+1:0] w_dsub;
  logic             w_dfit;

  assign w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_dsub   = {1'b0, w_dshift} - {2'b00, r_mag_b};
  assign w_dfit   = !w_dsub[WIDTH+1];

  // Sign fix-up of the final magnitudes.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_signed;
  logic [WIDTH-1:0]   w_quo_signed;
  logic [WIDTH-1:0]   w_rem_signed;

  assign w_prod        = {r_acc_hi, r_acc_lo};
  assign w_prod_signed = (r_neg_a ^ r_neg_b) ? ('0 - w_prod) : w_prod;
  assign w_quo_signed  = (r_neg_a ^ r_neg_b) ? ('0 - r_acc_lo) : r_acc_lo;
  assign w_rem_signed  = r_neg_a ? ('0 - r_acc_hi) : r_acc_hi;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mult) begin
          w_state_next = S_MULT;
        end else if (w_start_div && !w_b_zero) begin
          w_state_next = S_DIV;
        end else if (w_start_div) begin
          w_state_next = S_DONE;
        end
      end
      S_MULT:  if (w_last) w_state_next = S_FIX;
      S_DIV:   if (w_last) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration and result write-back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mult || (w_start_div && !w_b_zero)) begin
            r_count  <= '0;
            r_mag_a  <= w_abs_a;
            r_mag_b  <= w_abs_b;
            r_acc_hi <= '0;
            r_acc_lo <= w_start_mult ? w_abs_b : w_abs_a;
            r_neg_a  <= A[WIDTH-1];
            r_neg_b  <= B[WIDTH-1];
            r_is_div <= !w_start_mult;
          end
        end
        S_MULT: begin
          r_count  <= r_count + CW'(1);
          r_acc_hi <= w_madd[WIDTH:1];
          r_acc_lo <= {w_madd[0], r_acc_lo[WIDTH-1:1]};
        end
        S_DIV: begin
          r_count  <= r_count + CW'(1);
          r_acc_hi <= w_dfit ? w_dsub[WIDTH-1:0] : w_dshift[WIDTH-1:0];
          r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_dfit};
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_signed;
            r_lo <= w_quo_signed;
          end else begin
            r_hi <= w_prod_signed[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_signed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status flags derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_busy    <= (w_state_next == S_MULT) || (w_state_next == S_DIV) ||
                   (w_state_next == S_FIX);
      r_done    <= (w_state_next == S_DONE);
      r_divzero <= (r_state == S_IDLE) && w_start_div && w_b_zero;
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign DivZero = r_divzero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic signed reference.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         MultControl;
  logic         DivControl;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;
  logic         DivZero;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: Hi/Lo as the unit should currently hold them.
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .MultControl (MultControl),
    .DivControl  (DivControl),
    .A           (A),
    .B           (B),
    .Hi          (Hi),
    .Lo          (Lo),
    .Busy        (Busy),
    .Done        (Done),
    .DivZero     (DivZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation: start, wait for Done (bounded), check latency and results.
  // disturb: pulse MultControl and change A/B ten cycles into the operation.
  // poke: request a multiply during the DONE cycle, which must be ignored.
  task automatic run_op(input bit is_mult, input bit is_div,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb, input bit poke);
    longint sa, sb, p, q, r;
    bit     dz;
    int     lat;
    int     n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (is_mult) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
    lat = dz ? 0 : W + 1;

    @(negedge clk);
    MultControl = is_mult;
    DivControl  = is_div;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    MultControl = 1'b0;
    DivControl  = 1'b0;
    A = $urandom;
    B = $urandom;
    if (!dz) chk("busy_start", Busy, 1);

    n = 0;
    while (!Done && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (disturb && n == 10) begin
        MultControl = 1'b1;
        A = $urandom;
        B = $urandom;
      end else begin
        MultControl = 1'b0;
      end
    end
    MultControl = 1'b0;
    chk("latency", n, lat);
    chk("hi", Hi, exp_hi);
    chk("lo", Lo, exp_lo);
    chk("divzero", DivZero, dz);
    chk("busy_at_done", Busy, 0);
    if (poke) MultControl = 1'b1;

    @(posedge clk);
    #1;
    MultControl = 1'b0;
    chk("done_pulse", Done, 0);
    chk("divzero_pulse", DivZero, 0);
    chk("idle_after", Busy, 0);
    @(posedge clk);
    #1;
    chk("still_idle", Busy, 0);
    $display("op %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0d lat=%0d",
             is_mult ? "MUL" : "DIV", a, b, Hi, Lo, DivZero, n);
  endtask

  logic [W-1:0] corners [5];

  initial begin
    reset = 1'b0;
    MultControl = 1'b0;
    DivControl  = 1'b0;
    A = '0;
    B = '0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_divzero", DivZero, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed operations.
    run_op(1, 0, 32'd7, 32'(-3), 0, 0);
    run_op(0, 1, 32'(-7), 32'd2, 0, 0);
    run_op(0, 1, 32'd5, 32'd0, 0, 0);
    run_op(1, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(0, 1, 32'd100000, 32'(-7), 1, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    run_op(0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);

    // Reset in the middle of a multiply aborts it and clears everything.
    @(negedge clk);
    MultControl = 1'b1;
    A = 32'd12345;
    B = 32'd678;
    @(posedge clk);
    #1;
    MultControl = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    chk("abort_hi", Hi, 0);
    chk("abort_lo", Lo, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    repeat (W + 4) @(posedge clk);
    #1;
    chk("abort_no_write_hi", Hi, 0);
    chk("abort_no_done", Done, 0);
    $display("reset abort during multiply -> hi=0x%08h lo=0x%08h busy=%0d", Hi, Lo, Busy);
    run_op(1, 0, 32'd12345, 32'd678, 0, 0);

    // Randomized operations with occasional corner operands and zero divisors.
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra, rb;
      bit           m;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      m  = $urandom_range(0, 1) == 1;
      run_op(m, !m, ra, rb, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
